// File: rtl/prog_loader_pkg.sv
// Shared constants for the program loader: FSM state encoding and default frame marker.
package prog_loader_pkg;

    localparam int          ADDR_W_DEF    = 8;
    localparam int          DATA_W_DEF    = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port bundles for the loader.
interface prog_stream_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input  in_ready);
    modport slave  (input  in_data, input  in_valid, output in_ready);
endinterface

interface imem_wr_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/loader_checksum.sv
// Registered mod-2**DATA_W byte accumulator; clear has priority over add.
module loader_checksum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] sum
);

    logic [DATA_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr)
            sum_d = '0;
        else if (add)
            sum_d = sum_q + din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sum_q <= '0;
        else
            sum_q <= sum_d;
    end

    assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// Framed program-image loader: SYNC, LEN, payload, checksum; writes imem and gates cpu_run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int               ADDR_W    = ADDR_W_DEF,
    parameter int               DATA_W    = DATA_W_DEF,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DATA_W'(SYNC_BYTE_DEF)
) (
    input  logic            clk,
    input  logic            rst_n,
    prog_stream_if.slave    s,
    imem_wr_if.master       m,
    input  logic            load_req,
    output logic            cpu_run,
    output logic            busy,
    output logic            err,
    output logic [ADDR_W:0] byte_count
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   byte_count_q, byte_count_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_run_q, cpu_run_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic              accept;
    logic              cs_clr, cs_add;
    logic [DATA_W-1:0] cs_sum;

    assign accept = s.in_valid & in_ready_q;

    loader_checksum #(.DATA_W(DATA_W)) u_csum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cs_clr),
        .add   (cs_add),
        .din   (s.in_data),
        .sum   (cs_sum)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        byte_count_d = byte_count_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cs_clr       = 1'b0;
        cs_add       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept && s.in_data == SYNC_BYTE) begin
                    state_d      = ST_LEN;
                    addr_d       = '0;
                    byte_count_d = '0;
                    cs_clr       = 1'b1;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    // A zero length byte encodes a full-depth image.
                    len_d   = (ADDR_W+1)'(s.in_data);
                    if (len_d == '0)
                        len_d = (ADDR_W+1)'(1) << ADDR_W;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = s.in_data;
                    cs_add       = 1'b1;
                    addr_d       = addr_q + 1'b1;
                    byte_count_d = byte_count_q + 1'b1;
                    len_d        = len_q - 1'b1;
                    if (len_q == (ADDR_W+1)'(1))
                        state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept)
                    state_d = (s.in_data == cs_sum) ? ST_DONE : ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (load_req)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered views of the next state.
        in_ready_d = !(state_d == ST_DONE || state_d == ST_ERROR);
        busy_d     = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CSUM);
        cpu_run_d  = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            byte_count_q <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            in_ready_q   <= 1'b1;
            cpu_run_q    <= 1'b0;
            busy_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            byte_count_q <= byte_count_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            in_ready_q   <= in_ready_d;
            cpu_run_q    <= cpu_run_d;
            busy_q       <= busy_d;
            err_q        <= err_d;
        end
    end

    assign s.in_ready   = in_ready_q;
    assign m.imem_we    = imem_we_q;
    assign m.imem_addr  = imem_addr_q;
    assign m.imem_wdata = imem_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign byte_count   = byte_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboarded bench for prog_loader: expected imem writes queued at stimulus, popped by a monitor.
module tb_prog_loader;

    logic       clk;
    logic       rst_n;
    logic       load_req;
    logic       cpu_run, busy, err;
    logic [8:0] byte_count;

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_q[$];

    prog_stream_if #(.DATA_W(8)) s ();
    imem_wr_if #(.ADDR_W(8), .DATA_W(8)) m ();

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (s),
        .m          (m),
        .load_req   (load_req),
        .cpu_run    (cpu_run),
        .busy       (busy),
        .err        (err),
        .byte_count (byte_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every imem_we must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && m.imem_we) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL imem_write: unexpected write addr=%02h data=%02h", m.imem_addr, m.imem_wdata);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({m.imem_addr, m.imem_wdata} !== e) begin
                    errors++;
                    $display("FAIL imem_write: got addr=%02h data=%02h expected addr=%02h data=%02h",
                             m.imem_addr, m.imem_wdata, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        s.in_valid = 1'b1;
        s.in_data  = b;
        @(posedge clk);
        #1;
        s.in_valid = 1'b0;
    endtask

    task automatic send_pay(input logic [7:0] k, input logic [7:0] b);
        exp_q.push_back({k, b});
        send(b);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rearm();
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        load_req   = 1'b0;
        s.in_valid = 1'b0;
        s.in_data  = 8'h00;
        #12;
        chk("reset_in_ready", s.in_ready, 1);
        chk("reset_cpu_run", cpu_run, 0);
        chk("reset_imem_addr", m.imem_addr, 0);
        chk("reset_byte_count", byte_count, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        gap(1);

        // Basic load: 12+34+56 = 9C
        send(8'hA5); send(8'h03);
        chk("basic_busy", busy, 1);
        send_pay(8'h00, 8'h12); send_pay(8'h01, 8'h34); send_pay(8'h02, 8'h56);
        chk("basic_run_before_csum", cpu_run, 0);
        send(8'h9C);
        chk("basic_cpu_run", cpu_run, 1);
        chk("basic_byte_count", byte_count, 3);
        chk("basic_in_ready", s.in_ready, 0);
        chk("basic_busy_done", busy, 0);
        gap(2);
        chk("basic_run_held", cpu_run, 1);

        // Re-arm from DONE: cpu_run drops the cycle after load_req
        rearm();
        chk("rearm_cpu_run", cpu_run, 0);
        chk("rearm_in_ready", s.in_ready, 1);

        // Bad checksum: 01+02 = 03, frame sends 04
        send(8'hA5); send(8'h02);
        send_pay(8'h00, 8'h01); send_pay(8'h01, 8'h02);
        send(8'h04);
        chk("bad_err", err, 1);
        chk("bad_cpu_run", cpu_run, 0);
        chk("bad_in_ready", s.in_ready, 0);
        chk("bad_byte_count", byte_count, 2);
        gap(2);
        chk("bad_err_sticky", err, 1);
        rearm();
        chk("bad_rearm_err", err, 0);
        chk("bad_rearm_in_ready", s.in_ready, 1);

        // Leading garbage discarded, gaps inside payload: 10+20+30+40 = A0
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("garbage_busy", busy, 0);
        send(8'hA5); send(8'h04);
        send_pay(8'h00, 8'h10); gap(1);
        send_pay(8'h01, 8'h20); gap(2);
        send_pay(8'h02, 8'h30); gap(3);
        chk("gap_byte_count", byte_count, 3);
        send_pay(8'h03, 8'h40);
        send(8'hA0);
        chk("gap_cpu_run", cpu_run, 1);
        chk("gap_byte_count_final", byte_count, 4);
        rearm();

        // Full wrap: N=0 means 256, sum 0..255 = 7F80 -> 80
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 256; i++)
            send_pay(8'(i), 8'(i));
        chk("wrap_busy_csum", busy, 1);
        send(8'h80);
        chk("wrap_cpu_run", cpu_run, 1);
        chk("wrap_byte_count", byte_count, 256);
        chk("wrap_last_addr", m.imem_addr, 8'hFF);
        gap(3);
        chk("wrap_no_extra", exp_q.size(), 0);
        rearm();

        // load_req during DATA is ignored: 01+02+03 = 06
        send(8'hA5); send(8'h03);
        load_req = 1'b1;
        send_pay(8'h00, 8'h01);
        load_req = 1'b0;
        chk("data_rearm_busy", busy, 1);
        send_pay(8'h01, 8'h02); send_pay(8'h02, 8'h03);
        send(8'h06);
        chk("data_rearm_cpu_run", cpu_run, 1);
        rearm();

        // Reset mid-frame after 2 of 4 payload bytes
        send(8'hA5); send(8'h04);
        send_pay(8'h00, 8'hC1); send_pay(8'h01, 8'hC2);
        @(negedge clk);
        #1;
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_byte_count", byte_count, 0);
        chk("midrst_in_ready", s.in_ready, 1);
        chk("midrst_imem_we", m.imem_we, 0);
        chk("midrst_imem_addr", m.imem_addr, 0);
        chk("midrst_imem_wdata", m.imem_wdata, 0);
        chk("midrst_cpu_run", cpu_run, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        gap(1);

        // New frame after reset starts at address 0: 77+88 = FF
        send(8'hA5); send(8'h02);
        send_pay(8'h00, 8'h77); send_pay(8'h01, 8'h88);
        send(8'hFF);
        chk("post_rst_cpu_run", cpu_run, 1);
        chk("post_rst_byte_count", byte_count, 2);
        gap(2);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction-memory fetch path: receives a framed program image over a byte-stream valid/ready interface and writes it into the 256x8 instruction memory the CPU reads by PC.
- Holds the CPU in halt (cpu_run=0) during loading; releases it only after a checksum-verified frame.
- Sits between a host byte source (UART RX or bench) and the instruction memory write port.

Parameters:
- ADDR_W, 8, instruction memory address width; depth = 2**ADDR_W.
- DATA_W, 8, instruction/byte width.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-low reset (0 = reset).
- in_data  input  DATA_W  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader accepts a byte; transfer occurs when in_valid & in_ready at a rising CLK edge.
- load_req  input  1  single-cycle pulse; re-arms the loader from DONE or ERROR.
- imem_we  output  1  instruction memory write enable, one-cycle pulse per byte.
- imem_addr  output  ADDR_W  write address.
- imem_wdata  output  DATA_W  write data.
- cpu_run  output  1  1 = CPU may run (PC register enabled); 0 = CPU held.
- busy  output  1  frame in progress (states LEN, DATA, CSUM).
- err  output  1  last frame failed checksum; sticky until load_req or reset.
- byte_count  output  ADDR_W+1  payload bytes written in the current/last frame.

Behaviour:
- Reset (async, Reset=0): state=IDLE. Outputs: in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_run=0, busy=0, err=0, byte_count=0. Internal checksum=0, remaining length=0. A reset asserted mid-frame aborts it; words already written stay in memory, and cpu_run stays 0.
- All outputs are registered.
- States and transitions (all on an accepted byte unless stated):
  - IDLE: SYNC_BYTE -> LEN, clearing checksum, address and byte_count. Any other byte is discarded.
  - LEN: latch N = in_data; N=0 means 256 (2**ADDR_W) -> DATA.
  - DATA: emit write; checksum += byte (mod 2**DATA_W); address++ ; byte_count++. When the last of N bytes is accepted -> CSUM.
  - CSUM: byte == checksum -> DONE, else -> ERROR.
  - DONE: cpu_run=1, in_ready=0. load_req -> IDLE, cpu_run=0 in the next cycle.
  - ERROR: err=1, cpu_run=0, in_ready=0. load_req -> IDLE and clears err.
  - load_req in IDLE/LEN/DATA/CSUM is ignored.
- in_ready = 1 in IDLE, LEN, DATA and CSUM (one byte per cycle sustained, no back-pressure); 0 in DONE and ERROR.
- Write latency: a byte accepted at edge t appears at edge t+1 as imem_we=1 with imem_addr=k, imem_wdata=byte. Payload byte k (0-based) goes to address k.
- Address counter is ADDR_W bits. With N=256 the last write is to 0xFF and the counter wraps to 0 with no extra write. byte_count reaches 256, hence its ADDR_W+1 width.
- A SYNC_BYTE value inside LEN/DATA/CSUM is treated as data; there is no resync.
- Gaps (in_valid=0) in any state hold the state; imem_we=0 in gap cycles.
- cpu_run rises the cycle after the checksum byte is accepted; the CPU's PC must be held at 0 while cpu_run=0.

Decomposition:
- Shared package (prog_loader_pkg): state encoding localparams (ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERROR, 3-bit) and the default SYNC_BYTE constant.
- One natural sub-module: loader_checksum (registered mod-2**DATA_W accumulator with clear and add-enable). The address counter is reused from the existing adder8 increment style.
- Everything else stays in prog_loader.

Test Plan:
- Basic load: A5, 03, 12, 34, 56, checksum 9C, back-to-back -> writes (00,12),(01,34),(02,56) on consecutive cycles; cpu_run=1 one cycle after 9C; byte_count=3; in_ready=0.
- Bad checksum: A5, 02, 01, 02, 04 -> two writes; state ERROR, err=1, cpu_run=0. Then a load_req pulse -> err=0, in_ready=1. A valid frame then loads normally.
- Full wrap: A5, 00, then 256 bytes of value i, checksum 80 -> last write at addr FF; byte_count=256; cpu_run=1; no write to addr 00 after FF.
- Garbage and gaps: 00, FF, 5A before A5, with in_valid=0 gaps of 1-3 cycles inside the payload -> leading bytes discarded, no imem_we in gap cycles, correct addresses, DONE reached.
- Reset mid-frame: Reset=0 after 2 of 4 payload bytes -> all outputs at reset values immediately (asynchronous). After release a new frame loads from addr 0.
- Re-arm: load_req while in DONE -> cpu_run falls the next cycle; load_req while in DATA -> ignored, frame completes.
